// File: rtl/fetch_prefetch_queue.sv
// Sequential-index fetch stage with a DEPTH-entry prefetch FIFO and PC-relative redirect.
// Optional perf counters (perf_bubbles, perf_redirects) are enabled by defining FETCH_PERF_EN.
module fetch_prefetch_queue #(
    parameter int                INSTR_W     = 16,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_INDEX = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               cache_en,
    output logic [ADDR_W-1:0]  cache_index,
    input  logic [INSTR_W-1:0] cache_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_index,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_redirects,
`endif
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_delta
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [ADDR_W-1:0]  fetch_idx;
    logic [ADDR_W-1:0]  head_idx;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic signed [ADDR_W-1:0] delta_s;
    logic [ADDR_W-1:0]        target;
    logic [SUM_W-1:0]         outstanding;
    logic                     issue;
    logic                     push;
    logic                     pop;

    assign delta_s     = redirect_delta;
    assign target      = head_idx + $unsigned(delta_s);
    // Slots already claimed: queued entries, the returning read and the read issued now.
    assign outstanding = SUM_W'(count) + SUM_W'(inflight) + SUM_W'(cache_en);
    assign issue       = outstanding < SUM_W'(DEPTH);
    assign push        = inflight;
    assign pop         = out_valid & out_ready;

    assign cache_index = fetch_idx;
    assign out_valid   = (count != '0);
    assign out_instr   = mem[rd_ptr];
    assign out_index   = head_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_idx <= RESET_INDEX;
            head_idx  <= RESET_INDEX;
            count     <= '0;
            inflight  <= 1'b0;
            cache_en  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (redirect_valid) begin
            // Flush everything, including the read issued this cycle.
            fetch_idx <= target;
            head_idx  <= target;
            count     <= '0;
            inflight  <= 1'b0;
            cache_en  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            cache_en <= issue;
            inflight <= cache_en;
            if (cache_en)
                fetch_idx <= fetch_idx + ADDR_W'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                head_idx <= head_idx + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && push)
            mem[wr_ptr] <= cache_data;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !redirect_valid && count == CNT_W'(DEPTH)));

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            if (!out_valid)
                perf_bubbles <= sat_inc(perf_bubbles);
            if (redirect_valid)
                perf_redirects <= sat_inc(perf_redirects);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, stall/drain, redirects, wrap and mid-stream reset.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst, rst_w;
    logic        cache_en, cache_en_w;
    logic [31:0] cache_index, cache_index_w;
    logic [15:0] cache_data, cache_data_w;
    logic        out_valid, out_valid_w;
    logic        out_ready, out_ready_w;
    logic [15:0] out_instr, out_instr_w;
    logic [31:0] out_index, out_index_w;
    logic        redirect_valid, redirect_valid_w;
    logic [31:0] redirect_delta, redirect_delta_w;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles, perf_redirects, perf_bubbles_w, perf_redirects_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.INSTR_W(16), .ADDR_W(32), .DEPTH(4), .RESET_INDEX(32'd10)) u_dut (
        .clk(clk), .rst(rst), .cache_en(cache_en), .cache_index(cache_index),
        .cache_data(cache_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_index(out_index),
`ifdef FETCH_PERF_EN
        .perf_bubbles(perf_bubbles), .perf_redirects(perf_redirects),
`endif
        .redirect_valid(redirect_valid), .redirect_delta(redirect_delta)
    );

    fetch_prefetch_queue #(.INSTR_W(16), .ADDR_W(32), .DEPTH(4), .RESET_INDEX(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst(rst_w), .cache_en(cache_en_w), .cache_index(cache_index_w),
        .cache_data(cache_data_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_instr(out_instr_w), .out_index(out_index_w),
`ifdef FETCH_PERF_EN
        .perf_bubbles(perf_bubbles_w), .perf_redirects(perf_redirects_w),
`endif
        .redirect_valid(redirect_valid_w), .redirect_delta(redirect_delta_w)
    );

    function automatic logic [15:0] f(input logic [31:0] i);
        return i[15:0] ^ 16'hA5A5;
    endfunction

    // ICache model: one-cycle read latency.
    always @(posedge clk) begin
        cache_data   <= f(cache_index);
        cache_data_w <= f(cache_index_w);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_delta = '0;
        repeat (3) step();
        n_checks++; if (cache_en !== 1'b0) begin n_fail++; $display("FAIL reset_cache_en got %b exp 0", cache_en); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_index !== 32'd10) begin n_fail++; $display("FAIL reset_out_index got %0d exp 10", out_index); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_bubbles !== 32'd0) begin n_fail++; $display("FAIL reset_perf_bubbles got %0d exp 0", perf_bubbles); end
`endif
    endtask

    task automatic test_stream();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++; if (cache_en !== 1'b1 || cache_index !== 32'(10 + k - 1)) begin
                n_fail++; $display("FAIL stream_req k=%0d got en=%b idx=%0d exp en=1 idx=%0d", k, cache_en, cache_index, 10 + k - 1); end
            if (k < 3) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid k=%0d got %b exp 0", k, out_valid); end
            end else begin
                n_checks++; if (out_valid !== 1'b1 || out_index !== 32'(10 + k - 3) || out_instr !== f(32'(10 + k - 3))) begin
                    n_fail++; $display("FAIL stream_out k=%0d got v=%b idx=%0d instr=%h exp v=1 idx=%0d", k, out_valid, out_index, out_instr, 10 + k - 3); end
            end
`ifdef FETCH_PERF_EN
            if (k == 3) begin
                n_checks++; if (perf_bubbles !== 32'd3) begin n_fail++; $display("FAIL stream_bubbles got %0d exp 3", perf_bubbles); end
            end
`endif
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        logic [31:0] first_idx = 32'hDEAD_BEEF;
        logic seen = 1'b0;
        rst = 1'b1; out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cache_en) begin
                n_checks++; if (cache_index !== 32'(10 + nreq)) begin n_fail++; $display("FAIL stall_req_idx got %0d exp %0d", cache_index, 10 + nreq); end
                nreq++;
            end
        end
        n_checks++; if (nreq != 4) begin n_fail++; $display("FAIL stall_req_count got %0d exp 4", nreq); end
        n_checks++; if (u_dut.count !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d exp 4", u_dut.count); end
        n_checks++; if (out_valid !== 1'b1 || out_index !== 32'd10 || out_instr !== f(32'd10)) begin
            n_fail++; $display("FAIL stall_head got v=%b idx=%0d instr=%h exp v=1 idx=10", out_valid, out_index, out_instr); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_index !== 32'(10 + i) || out_instr !== f(32'(10 + i))) begin
                n_fail++; $display("FAIL drain i=%0d got v=%b idx=%0d instr=%h exp v=1 idx=%0d", i, out_valid, out_index, out_instr, 10 + i); end
            if (cache_en && !seen) begin seen = 1'b1; first_idx = cache_index; end
            step();
        end
        n_checks++; if (first_idx !== 32'd14) begin n_fail++; $display("FAIL resume_idx got %h exp 14", first_idx); end
    endtask

    task automatic test_redirect();
        rst = 1'b1; out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 32'd11) begin n_fail++; $display("FAIL redir_pre got v=%b idx=%0d exp v=1 idx=11", out_valid, out_index); end
        redirect_valid = 1'b1; redirect_delta = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (cache_en !== 1'b0 || out_valid !== 1'b0 || out_index !== 32'd9) begin
            n_fail++; $display("FAIL redir_next got en=%b v=%b idx=%0d exp en=0 v=0 idx=9", cache_en, out_valid, out_index); end
        step();
        n_checks++; if (cache_en !== 1'b1 || cache_index !== 32'd9 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_req got en=%b idx=%0d v=%b exp en=1 idx=9 v=0", cache_en, cache_index, out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale got v=%b exp 0", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 32'd9 || out_instr !== f(32'd9)) begin
            n_fail++; $display("FAIL redir_first got v=%b idx=%0d instr=%h exp v=1 idx=9", out_valid, out_index, out_instr); end
    endtask

    task automatic test_back_to_back();
        n_checks++; if (u_dut.inflight !== 1'b1 || out_valid !== 1'b1 || out_index !== 32'd9) begin
            n_fail++; $display("FAIL coll_pre got infl=%b v=%b idx=%0d exp infl=1 v=1 idx=9", u_dut.inflight, out_valid, out_index); end
        redirect_valid = 1'b1; redirect_delta = 32'd5;
        step();
        n_checks++; if (u_dut.count !== 3'd0 || out_valid !== 1'b0 || out_index !== 32'd14 || u_dut.inflight !== 1'b0) begin
            n_fail++; $display("FAIL coll_post got cnt=%0d v=%b idx=%0d infl=%b exp cnt=0 v=0 idx=14 infl=0", u_dut.count, out_valid, out_index, u_dut.inflight); end
        redirect_delta = 32'd3;
        step();
        n_checks++; if (out_index !== 32'd17) begin n_fail++; $display("FAIL b2b_first got %0d exp 17", out_index); end
        redirect_delta = 32'hFFFF_FFF9;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (out_index !== 32'd10 || cache_en !== 1'b0) begin n_fail++; $display("FAIL b2b_second got idx=%0d en=%b exp idx=10 en=0", out_index, cache_en); end
        step();
        n_checks++; if (cache_en !== 1'b1 || cache_index !== 32'd10) begin n_fail++; $display("FAIL b2b_req got en=%b idx=%0d exp en=1 idx=10", cache_en, cache_index); end
        repeat (2) step();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 32'd10 || out_instr !== f(32'd10)) begin
            n_fail++; $display("FAIL b2b_deliver got v=%b idx=%0d instr=%h exp v=1 idx=10", out_valid, out_index, out_instr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_redirects !== 32'd4) begin n_fail++; $display("FAIL perf_redirects got %0d exp 4", perf_redirects); end
`endif
    endtask

    task automatic test_wrap();
        rst_w = 1'b0;
        step();
        n_checks++; if (cache_en_w !== 1'b1 || cache_index_w !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL wrap_req got en=%b idx=%h exp en=1 idx=fffffffe", cache_en_w, cache_index_w); end
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid_w !== 1'b1 || out_index_w !== 32'hFFFF_FFFE + 32'(i) || out_instr_w !== f(32'hFFFF_FFFE + 32'(i))) begin
                n_fail++; $display("FAIL wrap_pop i=%0d got v=%b idx=%h exp v=1 idx=%h", i, out_valid_w, out_index_w, 32'hFFFF_FFFE + 32'(i)); end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        n_checks++; if (u_dut.inflight !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got infl=%b exp 1", u_dut.inflight); end
        rst = 1'b1; redirect_valid = 1'b1; redirect_delta = 32'd100;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || cache_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got v=%b en=%b exp v=0 en=0", out_valid, cache_en); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_bubbles !== 32'd0 || perf_redirects !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_perf got b=%0d r=%0d exp 0 0", perf_bubbles, perf_redirects); end
`endif
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++; if (cache_en !== 1'b1 || cache_index !== 32'(10 + k - 1)) begin
                n_fail++; $display("FAIL rstmid_req k=%0d got en=%b idx=%0d exp en=1 idx=%0d", k, cache_en, cache_index, 10 + k - 1); end
            n_checks++; if (out_valid !== (k >= 3)) begin n_fail++; $display("FAIL rstmid_valid k=%0d got %b exp %b", k, out_valid, k >= 3); end
        end
        n_checks++; if (out_index !== 32'd11 || out_instr !== f(32'd11)) begin
            n_fail++; $display("FAIL rstmid_head got idx=%0d instr=%h exp idx=11", out_index, out_instr); end
    endtask

    initial begin
        rst_w = 1'b1; out_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_delta_w = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised next-generation fetch stage.
- Generates sequential instruction indices and issues them to the ICache read port.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake, each tagged with its index.
- Supports PC-relative redirects (signed delta) that flush the queue and kill the in-flight cache read.

Parameters:
- INSTR_W, 16, instruction width in bits.
- ADDR_W, 32, index width in bits; index arithmetic wraps modulo 2^ADDR_W.
- DEPTH, 4, FIFO entries; power of two, at least 2. At least 3 is required for 1 instr/cycle throughput.
- RESET_INDEX, 0, first index fetched after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cache_en  out  1  ICache read request this cycle.
- cache_index  out  ADDR_W  index requested.
- cache_data  in  INSTR_W  read data; valid the cycle after cache_en=1.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head entry.
- out_instr  out  INSTR_W  head instruction.
- out_index  out  ADDR_W  index of the head instruction. When the queue is empty, this is the index that will next enter the queue.
- redirect_valid  in  1  redirect request.
- redirect_delta  in  ADDR_W  signed two's-complement offset.

Behaviour:
- Registers:
  - fetch_idx: next index to request.
  - head_idx: drives out_index.
  - count: 0..DEPTH.
  - inflight: 1 bit.
  - FIFO storage with wrapping rd/wr pointers.
- Reset, while rst=1 at an edge:
  - fetch_idx=RESET_INDEX, head_idx=RESET_INDEX, count=0, inflight=0, pointers=0.
  - Outputs: cache_en=0, out_valid=0.
  - FIFO contents are don't-care.
  - Reset mid-operation discards any in-flight read; its data is never enqueued.
- Request issue (registered):
  - cache_en is asserted when not resetting, no redirect this cycle, and count + inflight + (cache_en this cycle) < DEPTH, with pop ignored.
  - cache_index = fetch_idx. fetch_idx increments by 1 per issued request.
- Response: inflight=1 means cache_data is written into the FIFO at the next edge and count increments. There is no bypass.
- Latency:
  - First cache_en occurs in the cycle after rst falls.
  - out_valid rises 2 cycles after that request.
- Pop: out_valid & out_ready → rd pointer advances, head_idx += 1, count decrements.
- Simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0); out_instr = FIFO[rd].
- Full: no request is issued, so overflow is impossible. Pushing when count==DEPTH is an assertion error.
- Empty: out_valid=0; out_ready is ignored.
- Redirect, when redirect_valid=1 at an edge:
  - Target = head_idx + redirect_delta (signed, wraps).
  - Sets fetch_idx=target and head_idx=target.
  - Clears count and both pointers.
  - Kills the in-flight response, which is not enqueued.
  - No cache_en in the following cycle; the request to the target is issued the cycle after.
  - Redirect has priority over the same-cycle pop and push.
  - A redirect while rst=1 is ignored.
- Back-to-back redirects: each uses the head_idx updated by the previous one.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two output ports:
  - perf_bubbles (32 bits): counts cycles with rst=0 and out_valid=0.
  - perf_redirects (32 bits): counts accepted redirects.
  - Both counters are zeroed by rst and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset release, out_ready=1, DEPTH=4, RESET_INDEX=10:
  - cache_index sequence 10,11,12...
  - First out_valid appears 2 cycles after the first cache_en, with out_index=10.
  - Thereafter 1 instr/cycle, out_index incrementing 10,11,12.
- out_ready=0 held:
  - Exactly 4 requests issued (indices 10..13), then cache_en=0.
  - count=4, out_index=10 stable.
  - Raising out_ready drains 10,11,12,13 in order, and fetching resumes at 14.
- Redirect with head at index 11, delta=-2:
  - Queue flushed and in-flight data dropped.
  - Next cycle: cache_en=0 and out_index=9.
  - Next request is index 9; next delivered instruction is index 9.
- Redirect asserted in the same cycle as a response arrives and out_ready=1:
  - Response discarded, no pop recorded, count=0 afterwards.
- Wrap: RESET_INDEX=0xFFFFFFFE, run 4 pops → out_index 0xFFFFFFFE, 0xFFFFFFFF, 0, 1.
- rst asserted mid-stream with a read in flight:
  - Next cycle: out_valid=0, cache_en=0.
  - After release, fetch restarts at RESET_INDEX with no stale entry delivered.
  - With FETCH_PERF_EN defined, both counters read 0.
